// File: rtl/sf_snp_ctrl.sv
// sf_snp_ctrl: snoop-filter snoop controller.
//
// Takes one snoop job at a time from the SF lookup stage, issues one snoop
// per cycle to every RN-F sharer other than the requester, collects the
// snoop responses (in any order) and reports completion with the
// accumulated PassDirty and error status.
//
// Ports
//   clock, reset                       sole clock; asynchronous active-low reset
//   req_valid/req_ready                snoop job handshake
//   req_addr/txnid/srcid/unique/sharers  job payload
//   snp_valid/snp_ready                outgoing snoop handshake
//   snp_addr/opcode/txnid/tgtid        snoop payload
//   rsp_valid/rsp_ready                SnpResp handshake
//   rsp_srcid/rsp_passdirty            response payload
//   done_valid/done_ready              completion handshake
//   done_txnid/dirty/err               completion payload
module sf_snp_ctrl #(
    parameter int NUM_RN     = 4,
    parameter int RN_BASE_ID = 1,
    parameter int TXNID_W    = 12,
    parameter int NODEID_W   = 7
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [47:0]         req_addr,
    input  logic [TXNID_W-1:0]  req_txnid,
    input  logic [NODEID_W-1:0] req_srcid,
    input  logic                req_unique,
    input  logic [NUM_RN-1:0]   req_sharers,

    output logic                snp_valid,
    input  logic                snp_ready,
    output logic [44:0]         snp_addr,
    output logic [4:0]          snp_opcode,
    output logic [TXNID_W-1:0]  snp_txnid,
    output logic [NODEID_W-1:0] snp_tgtid,

    input  logic                rsp_valid,
    output logic                rsp_ready,
    input  logic [NODEID_W-1:0] rsp_srcid,
    input  logic                rsp_passdirty,

    output logic                done_valid,
    input  logic                done_ready,
    output logic [TXNID_W-1:0]  done_txnid,
    output logic                done_dirty,
    output logic                done_err
);

    localparam logic [4:0] OP_SNP_SHARED = 5'h01;
    localparam logic [4:0] OP_SNP_UNIQUE = 5'h07;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [44:0]         addr_reg;
    logic [TXNID_W-1:0]  txnid_reg;
    logic [4:0]          opcode_reg;
    logic [NUM_RN-1:0]   send_mask_reg, send_mask_next;
    logic [NUM_RN-1:0]   wait_mask_reg, wait_mask_next;
    logic                dirty_reg, dirty_next;
    logic                err_reg, err_next;
    logic                accept;

    // Line offset bits are not part of the snoop address.
    logic                unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[2:0];

    // NodeID -> RN index decode. A NodeID outside the tracked range decodes
    // to all zeros, so it neither clears a sharer nor matches a wait bit.
    logic [NUM_RN-1:0]   req_onehot;
    logic [NUM_RN-1:0]   rsp_onehot;

    generate
        for (genvar gi = 0; gi < NUM_RN; gi++) begin : g_id_decode
            assign req_onehot[gi] = (32'(req_srcid) == 32'(RN_BASE_ID + gi));
            assign rsp_onehot[gi] = (32'(rsp_srcid) == 32'(RN_BASE_ID + gi));
        end
    endgenerate

    // Lowest pending target: one-hot bit and its NodeID.
    logic [NUM_RN-1:0]   snp_onehot;
    logic [NODEID_W-1:0] snp_tgt_id;

    always_comb begin
        snp_onehot = '0;
        snp_tgt_id = '0;
        for (int i = NUM_RN - 1; i >= 0; i--) begin
            if (send_mask_reg[i]) begin
                snp_onehot = '0;
                snp_onehot[i] = 1'b1;
                snp_tgt_id = NODEID_W'(RN_BASE_ID + i);
            end
        end
    end

    // A response is only legitimate for a snoop already sent in an earlier
    // cycle, so the match is taken against the registered wait mask.
    logic rsp_match;
    assign rsp_match = |(rsp_onehot & wait_mask_reg);

    always_comb begin
        state_next     = state_reg;
        send_mask_next = send_mask_reg;
        wait_mask_next = wait_mask_reg;
        dirty_next     = dirty_reg;
        err_next       = err_reg;
        accept         = 1'b0;
        req_ready      = 1'b0;
        snp_valid      = 1'b0;
        rsp_ready      = 1'b0;
        done_valid     = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept         = 1'b1;
                    send_mask_next = req_sharers & ~req_onehot;
                    wait_mask_next = '0;
                    dirty_next     = 1'b0;
                    err_next       = 1'b0;
                    state_next     = (|send_mask_next) ? SEND : DONE;
                end
            end

            SEND: begin
                snp_valid = 1'b1;
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    if (rsp_match) begin
                        wait_mask_next = wait_mask_reg & ~rsp_onehot;
                        dirty_next     = dirty_reg | rsp_passdirty;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                if (snp_ready) begin
                    send_mask_next = send_mask_reg & ~snp_onehot;
                    wait_mask_next = wait_mask_next | snp_onehot;
                    if (send_mask_next == '0) begin
                        state_next = (wait_mask_next == '0) ? DONE : WAIT;
                    end
                end
            end

            WAIT: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    if (rsp_match) begin
                        wait_mask_next = wait_mask_reg & ~rsp_onehot;
                        dirty_next     = dirty_reg | rsp_passdirty;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                // Leave as soon as the last response is taken so that the
                // completion is presented on the following cycle.
                if (wait_mask_next == '0) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_next     = IDLE;
                    send_mask_next = '0;
                    wait_mask_next = '0;
                    dirty_next     = 1'b0;
                    err_next       = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            send_mask_reg <= '0;
            wait_mask_reg <= '0;
            dirty_reg     <= 1'b0;
            err_reg       <= 1'b0;
            addr_reg      <= '0;
            txnid_reg     <= '0;
            opcode_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            send_mask_reg <= send_mask_next;
            wait_mask_reg <= wait_mask_next;
            dirty_reg     <= dirty_next;
            err_reg       <= err_next;
            if (accept) begin
                addr_reg   <= req_addr[47:3];
                txnid_reg  <= req_txnid;
                opcode_reg <= req_unique ? OP_SNP_UNIQUE : OP_SNP_SHARED;
            end
        end
    end

    // Payloads are driven only while their valid is up, so idle outputs
    // read as zero.
    assign snp_addr   = snp_valid  ? addr_reg   : '0;
    assign snp_opcode = snp_valid  ? opcode_reg : '0;
    assign snp_txnid  = snp_valid  ? txnid_reg  : '0;
    assign snp_tgtid  = snp_valid  ? snp_tgt_id : '0;
    assign done_txnid = done_valid ? txnid_reg  : '0;
    assign done_dirty = done_valid & dirty_reg;
    assign done_err   = done_valid & err_reg;

endmodule

// File: tb/tb_sf_snp_ctrl.sv
// tb_sf_snp_ctrl: self-checking bench for sf_snp_ctrl.
// Expected snoops and completions are queued when a job is driven and are
// compared by a monitor as the DUT hands them over; scenario tasks add
// their own inline checks for timing, stalls and reset behaviour.
module tb_sf_snp_ctrl;

    localparam int NUM_RN   = 4;
    localparam int TXNID_W  = 12;
    localparam int NODEID_W = 7;

    logic                clock;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [47:0]         req_addr;
    logic [TXNID_W-1:0]  req_txnid;
    logic [NODEID_W-1:0] req_srcid;
    logic                req_unique;
    logic [NUM_RN-1:0]   req_sharers;
    logic                snp_valid;
    logic                snp_ready;
    logic [44:0]         snp_addr;
    logic [4:0]          snp_opcode;
    logic [TXNID_W-1:0]  snp_txnid;
    logic [NODEID_W-1:0] snp_tgtid;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [NODEID_W-1:0] rsp_srcid;
    logic                rsp_passdirty;
    logic                done_valid;
    logic                done_ready;
    logic [TXNID_W-1:0]  done_txnid;
    logic                done_dirty;
    logic                done_err;

    sf_snp_ctrl #(
        .NUM_RN     (NUM_RN),
        .RN_BASE_ID (1),
        .TXNID_W    (TXNID_W),
        .NODEID_W   (NODEID_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_txnid     (req_txnid),
        .req_srcid     (req_srcid),
        .req_unique    (req_unique),
        .req_sharers   (req_sharers),
        .snp_valid     (snp_valid),
        .snp_ready     (snp_ready),
        .snp_addr      (snp_addr),
        .snp_opcode    (snp_opcode),
        .snp_txnid     (snp_txnid),
        .snp_tgtid     (snp_tgtid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_srcid     (rsp_srcid),
        .rsp_passdirty (rsp_passdirty),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .done_txnid    (done_txnid),
        .done_dirty    (done_dirty),
        .done_err      (done_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [NODEID_W-1:0] tgt;
        logic [4:0]          op;
        logic [44:0]         addr;
        logic [TXNID_W-1:0]  txnid;
    } snp_exp_t;

    typedef struct {
        logic [TXNID_W-1:0] txnid;
        logic               dirty;
        logic               err;
    } done_exp_t;

    snp_exp_t  exp_snp[$];
    done_exp_t exp_done[$];

    int total = 0;
    int bad   = 0;

    // Monitor: inputs change just after the rising edge, so values seen on
    // the falling edge are exactly what the next rising edge will act on.
    always @(negedge clock) begin
        if (snp_valid && snp_ready) begin
            total++;
            if (exp_snp.size() == 0) begin
                bad++;
                $display("FAIL snp_unexpected got tgt=%0d op=%h", snp_tgtid, snp_opcode);
            end else begin
                snp_exp_t e;
                e = exp_snp.pop_front();
                if (snp_tgtid !== e.tgt || snp_opcode !== e.op ||
                    snp_addr !== e.addr || snp_txnid !== e.txnid) begin
                    bad++;
                    $display("FAIL snp_payload got tgt=%0d op=%h addr=%h txn=%h want tgt=%0d op=%h addr=%h txn=%h",
                             snp_tgtid, snp_opcode, snp_addr, snp_txnid, e.tgt, e.op, e.addr, e.txnid);
                end else begin
                    $display("snoop  tgt=%0d op=%h addr=%h txn=%h ok", snp_tgtid, snp_opcode, snp_addr, snp_txnid);
                end
            end
        end
        if (done_valid && done_ready) begin
            total++;
            if (exp_done.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected got txn=%h dirty=%b err=%b", done_txnid, done_dirty, done_err);
            end else begin
                done_exp_t d;
                d = exp_done.pop_front();
                if (done_txnid !== d.txnid || done_dirty !== d.dirty || done_err !== d.err) begin
                    bad++;
                    $display("FAIL done_payload got txn=%h dirty=%b err=%b want txn=%h dirty=%b err=%b",
                             done_txnid, done_dirty, done_err, d.txnid, d.dirty, d.err);
                end else begin
                    $display("done   txn=%h dirty=%b err=%b ok", done_txnid, done_dirty, done_err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_snp(input logic [NODEID_W-1:0] tgt, input logic [4:0] op,
                            input logic [47:0] a, input logic [TXNID_W-1:0] t);
        snp_exp_t e;
        e.tgt = tgt; e.op = op; e.addr = a[47:3]; e.txnid = t;
        exp_snp.push_back(e);
    endtask

    task automatic push_done(input logic [TXNID_W-1:0] t, input logic dirty, input logic err);
        done_exp_t d;
        d.txnid = t; d.dirty = dirty; d.err = err;
        exp_done.push_back(d);
    endtask

    // Returns one cycle after the accepting edge (the first cycle of the job).
    task automatic do_req(input logic [47:0] a, input logic [TXNID_W-1:0] t,
                          input logic [NODEID_W-1:0] s, input logic u, input logic [NUM_RN-1:0] sh);
        int n;
        req_addr = a; req_txnid = t; req_srcid = s; req_unique = u; req_sharers = sh;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_accept_timeout got ready=%b want 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_rsp(input logic [NODEID_W-1:0] s, input logic pd);
        int n;
        rsp_srcid = s; rsp_passdirty = pd; rsp_valid = 1'b1;
        n = 0;
        while (rsp_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (rsp_ready !== 1'b1) begin
            bad++;
            $display("FAIL rsp_accept_timeout got ready=%b want 1", rsp_ready);
        end
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic wait_snp_drain();
        int n;
        n = 0;
        while (exp_snp.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (exp_snp.size() != 0) begin
            bad++;
            $display("FAIL snp_drain_timeout got pending=%0d want 0", exp_snp.size());
        end
    endtask

    task automatic wait_done_drain();
        int n;
        n = 0;
        while (exp_done.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (exp_done.size() != 0) begin
            bad++;
            $display("FAIL done_drain_timeout got pending=%0d want 0", exp_done.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if (snp_valid !== 1'b0 || rsp_ready !== 1'b0 || done_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valids got snp=%b rsp_rdy=%b done=%b want 000", snp_valid, rsp_ready, done_valid);
        end
        reset = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        total++;
        if (snp_addr !== '0 || snp_opcode !== '0 || snp_txnid !== '0 || snp_tgtid !== '0 ||
            done_txnid !== '0 || done_dirty !== 1'b0 || done_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_payload got addr=%h op=%h txn=%h tgt=%h dtxn=%h d=%b e=%b want all 0",
                     snp_addr, snp_opcode, snp_txnid, snp_tgtid, done_txnid, done_dirty, done_err);
        end
    endtask

    // No sharers, and a sharer vector that holds only the requester itself.
    task automatic test_no_targets();
        push_done(12'h011, 1'b0, 1'b0);
        do_req(48'h0000_1234_5678, 12'h011, 7'd1, 1'b0, 4'b0000);
        total++;
        if (done_valid !== 1'b1 || snp_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_tgt_latency got done=%b snp=%b want done=1 snp=0", done_valid, snp_valid);
        end
        wait_done_drain();

        push_done(12'h012, 1'b0, 1'b0);
        do_req(48'h0000_0000_1000, 12'h012, 7'd1, 1'b1, 4'b0001);
        total++;
        if (done_valid !== 1'b1 || snp_valid !== 1'b0) begin
            bad++;
            $display("FAIL self_only got done=%b snp=%b want done=1 snp=0", done_valid, snp_valid);
        end
        wait_done_drain();
    endtask

    task automatic test_two_snoops();
        logic [47:0] a;
        a = 48'hABCD_EF01_2348;
        push_snp(7'd2, 5'h01, a, 12'h0A1);
        push_snp(7'd4, 5'h01, a, 12'h0A1);
        push_done(12'h0A1, 1'b1, 1'b0);
        do_req(a, 12'h0A1, 7'd1, 1'b0, 4'b1011);
        wait_snp_drain();
        do_rsp(7'd4, 1'b1);
        do_rsp(7'd2, 1'b0);
        wait_done_drain();
    endtask

    task automatic test_stall();
        logic [47:0] a;
        a = 48'h0000_0BAD_F00F;
        push_snp(7'd2, 5'h07, a, 12'h3C3);
        push_snp(7'd3, 5'h07, a, 12'h3C3);
        push_done(12'h3C3, 1'b0, 1'b0);
        snp_ready = 1'b0;
        do_req(a, 12'h3C3, 7'd5, 1'b1, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (snp_valid !== 1'b1 || snp_tgtid !== 7'd2 || snp_opcode !== 5'h07) begin
                bad++;
                $display("FAIL stall_hold got v=%b tgt=%0d op=%h want v=1 tgt=2 op=07",
                         snp_valid, snp_tgtid, snp_opcode);
            end
            tick();
        end
        snp_ready = 1'b1;
        wait_snp_drain();
        do_rsp(7'd3, 1'b0);
        do_rsp(7'd2, 1'b0);
        wait_done_drain();
    endtask

    task automatic test_spurious();
        logic [47:0] a;
        a = 48'h1111_2222_3330;
        push_snp(7'd2, 5'h01, a, 12'h555);
        push_done(12'h555, 1'b1, 1'b1);
        do_req(a, 12'h555, 7'd3, 1'b0, 4'b0010);
        wait_snp_drain();
        do_rsp(7'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (done_valid !== 1'b0 || rsp_ready !== 1'b1) begin
                bad++;
                $display("FAIL spurious_wait got done=%b rsp_rdy=%b want done=0 rsp_rdy=1", done_valid, rsp_ready);
            end
            tick();
        end
        do_rsp(7'd2, 1'b1);
        wait_done_drain();
    endtask

    // One target, snp_ready high, response on the first possible cycle:
    // completion must appear three cycles after acceptance.
    task automatic test_latency();
        logic [47:0] a;
        a = 48'h0000_0000_7778;
        push_snp(7'd3, 5'h07, a, 12'h0F0);
        push_done(12'h0F0, 1'b0, 1'b0);
        do_req(a, 12'h0F0, 7'd2, 1'b1, 4'b0100);
        tick();
        rsp_srcid = 7'd3; rsp_passdirty = 1'b0; rsp_valid = 1'b1;
        total++;
        if (done_valid !== 1'b0 || rsp_ready !== 1'b1) begin
            bad++;
            $display("FAIL latency_wait got done=%b rsp_rdy=%b want done=0 rsp_rdy=1", done_valid, rsp_ready);
        end
        tick();
        rsp_valid = 1'b0;
        total++;
        if (done_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency_done got done=%b want 1", done_valid);
        end
        wait_done_drain();
    endtask

    task automatic test_reset_mid();
        logic [47:0] a;
        a = 48'h0000_4444_0008;
        push_snp(7'd4, 5'h01, a, 12'h777);
        do_req(a, 12'h777, 7'd1, 1'b0, 4'b1000);
        wait_snp_drain();
        total++;
        if (rsp_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_in_wait got rsp_rdy=%b want 1", rsp_ready);
        end
        reset = 1'b0;
        #1;
        total++;
        if (rsp_ready !== 1'b0 || snp_valid !== 1'b0 || done_valid !== 1'b0 || snp_tgtid !== '0) begin
            bad++;
            $display("FAIL mid_async_reset got rsp_rdy=%b snp=%b done=%b tgt=%0d want all 0",
                     rsp_ready, snp_valid, done_valid, snp_tgtid);
        end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1 || done_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_after_release got req_rdy=%b done=%b want 1 0", req_ready, done_valid);
        end
        push_done(12'h778, 1'b0, 1'b0);
        do_req(48'h0000_0000_0040, 12'h778, 7'd1, 1'b0, 4'b0000);
        wait_done_drain();
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_txnid = '0; req_srcid = '0;
        req_unique = 1'b0; req_sharers = '0;
        snp_ready = 1'b1;
        rsp_valid = 1'b0; rsp_srcid = '0; rsp_passdirty = 1'b0;
        done_ready = 1'b1;

        test_reset();
        test_no_targets();
        test_two_snoops();
        test_stall();
        test_spurious();
        test_latency();
        test_reset_mid();

        repeat (3) tick();
        total++;
        if (exp_snp.size() != 0 || exp_done.size() != 0) begin
            bad++;
            $display("FAIL queues_empty got snp=%0d done=%0d want 0 0", exp_snp.size(), exp_done.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got time=%0t want finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sf_snp_ctrl.md
SF_SNP_CTRL -- requirements
Module: sf_snp_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_RN, 4, number of RN-F tracked by SF; RN_BASE_ID, 1, NodeID of RN index 0 (RN i = RN_BASE_ID+i); TXNID_W, 12, TxnID width; NODEID_W, 7, NodeID width.
REQ-002 SHALL have ports (name direction width meaning): clock in 1 sole clock; reset in 1 asynchronous active-low reset.
REQ-003 req_valid in 1, req_ready out 1: snoop job handshake from SF lookup stage.
REQ-004 req_addr in 48 line address; req_txnid in TXNID_W; req_srcid in NODEID_W requester; req_unique in 1 (1 = ReadUnique); req_sharers in NUM_RN SF presence vector.
REQ-005 snp_valid out 1, snp_ready in 1; snp_addr out 45 (= req_addr[47:3]); snp_opcode out 5; snp_txnid out TXNID_W; snp_tgtid out NODEID_W.
REQ-006 rsp_valid in 1, rsp_ready out 1; rsp_srcid in NODEID_W; rsp_passdirty in 1: SnpResp channel.
REQ-007 done_valid out 1, done_ready in 1; done_txnid out TXNID_W; done_dirty out 1 (any PassDirty); done_err out 1 (unexpected response seen).

Function
REQ-008 SHALL implement FSM IDLE, SEND, WAIT, DONE; one job in flight.
REQ-009 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready.
REQ-010 On acceptance, SHALL latch addr, txnid, opcode, and target mask = req_sharers with bit of requester cleared (requester index = req_srcid-RN_BASE_ID when within 0..NUM_RN-1; otherwise nothing cleared).
REQ-011 Opcode SHALL be 5'h07 (SnpUnique) when req_unique=1, else 5'h01 (SnpShared).
REQ-012 Target mask nonzero -> SEND next cycle; target mask zero -> DONE next cycle (no snoops).
REQ-013 In SEND, snp_valid SHALL be 1 with snp_tgtid = RN_BASE_ID + lowest set index of send mask; snp_addr/opcode/txnid from latched job.
REQ-014 snp_valid/payload SHALL hold stable until snp_ready; on handshake clear that bit from send mask and set it in wait mask; at most one snoop per cycle.
REQ-015 Send mask becomes empty on handshake -> WAIT next cycle; if wait mask also empty at that point (all responses already in), -> DONE.
REQ-016 rsp_ready SHALL be 1 in SEND and WAIT, 0 in IDLE and DONE.
REQ-017 Accepted response whose srcid maps to a set wait-mask bit SHALL clear that bit and OR rsp_passdirty into dirty accumulator.
REQ-018 Accepted response with srcid outside range or bit not set in wait mask SHALL be dropped and set sticky err flag.
REQ-019 Response and snoop handshake in same cycle SHALL both take effect; a response may target the snoop handshaking that same cycle only if bit already in wait mask (else REQ-018).
REQ-020 WAIT -> DONE in the cycle after wait mask becomes empty; responses any order.
REQ-021 In DONE, done_valid=1 with done_txnid, done_dirty, done_err stable until done_ready; on handshake -> IDLE, clear dirty/err/masks.
REQ-022 Minimum latency: acceptance to done_valid = 1 cycle (no targets); N targets with snp_ready=1 and immediate responses = N+2 cycles.

Reset
REQ-023 Reset low SHALL asynchronously force IDLE, masks/dirty/err 0; outputs: req_ready 1 after release, snp_valid 0, rsp_ready 0, done_valid 0, all payload outputs 0.
REQ-024 Reset asserted mid-job SHALL abandon job with no done report; first cycle after release is IDLE.

Verification
REQ-025 Sharers 4'b0000, srcid 1 -> no snp_valid; done_valid next cycle, dirty 0, err 0.
REQ-026 Sharers 4'b1011, srcid 1 (RN0), unique=0, snp_ready=1 -> snoops tgtid 2 then 4, opcode 5'h01; responses from 4 then 2, 4 with passdirty -> done_dirty 1.
REQ-027 Sharers 4'b0110, unique=1, snp_ready low 3 cycles -> snp_valid held, tgtid 2 stable, opcode 5'h07; then tgtid 3.
REQ-028 Spurious response srcid 9 during WAIT -> ignored, done_err 1, job still waits for real responses.
REQ-029 Reset asserted during WAIT -> all outputs to reset values immediately; next req accepted normally.
